m_stage_dmem: RTL and testbench
===============================

Name: m_stage_dmem

Overview:
- Memory-stage data memory and load/store unit.
- Consumes the M-stage outputs of the E/M pipeline register (m_instr, m_aluout, m_DMinput, m_pc) and performs the access.
- Word, half and byte stores are committed with byte enables at the clock edge.
- Word, half and byte loads return extended read data combinationally to the M/W register and the forwarding path.
- Misaligned and out-of-range accesses are suppressed and flagged.

Parameters:
- DEPTH, 3072, number of 32-bit words; byte address space is 0 to 4*DEPTH-1.
- ADDR_W, 12, word-index width (ceil(log2(DEPTH))).
- LOG_EN, 1, when 1, print a write trace line for every committed store.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (reset=0 resets at the clock edge).
- m_instr  in  32  M-stage instruction; opcode in [31:26].
- m_aluout  in  32  effective byte address.
- m_DMinput  in  32  store data, already forwarded.
- m_pc  in  32  M-stage PC, used for trace only.
- m_dmout  out  32  load result after byte/half select and extension.
- m_is_load  out  1  M-stage instruction is lw/lh/lhu/lb/lbu.
- m_is_store  out  1  M-stage instruction is sw/sh/sb.
- m_addr_err  out  1  current access is misaligned or out of range.
- m_byteen  out  4  byte enables applied this cycle; bit i = byte lane i (little-endian).

Behaviour:
- Opcode decode:
  - lw 6'h23, lh 6'h21, lhu 6'h25, lb 6'h20, lbu 6'h24.
  - sw 6'h2b, sh 6'h29, sb 6'h28.
  - Any other opcode: no access, m_byteen=0, m_dmout=0.
- Word index = m_aluout[ADDR_W+1:2]. Lane = m_aluout[1:0].
- Error conditions:
  - Word access with lane != 0.
  - Half access with lane[0] = 1.
  - Address >= 4*DEPTH.
  - m_addr_err is asserted only for load/store opcodes.
- Byte enables:
  - sw -> 4'b1111.
  - sh -> 4'b0011 << lane.
  - sb -> 4'b0001 << lane.
  - Forced to 0 when m_addr_err=1.
- Store data is replicated into all lanes: half -> {2{m_DMinput[15:0]}}, byte -> {4{m_DMinput[7:0]}}.
- Store commit:
  - At posedge clk with reset=1 and m_byteen != 0, the enabled lanes of mem[index] are written. Other lanes are untouched.
  - Write-back latency is 1 cycle: a load of the same word in the next cycle sees the new data.
- Load path is combinational, same cycle, reading the selected word.
  - lw: full word.
  - lh: sign-extend the selected half. lhu: zero-extend it.
  - lb: sign-extend the selected byte. lbu: zero-extend it.
  - On error, m_dmout=0.
- Reset (reset=0 at posedge):
  - All memory words are cleared to 0 in that same edge.
  - Any store presented in that cycle is dropped.
  - Combinational outputs follow the inputs; with the NOP (instr=0) that the E/M register emits during reset/stall, all outputs are 0.
- Bubbles: instr=0 decodes as a non-memory op, so no write and no trace.
- Trace, when LOG_EN=1 and a store commits:
  - Print "@<pc 8 hex>: *<word-aligned addr 8 hex> <= <full updated word 8 hex>".
  - Printed exactly once per commit, at the commit edge.
- Simultaneous events: reset wins over store. There is a single port, so there are no read/write conflicts within the stage.

Decomposition:
- Shared package: opcode constants (OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB) and the mem-access-size enum (SZ_NONE/SZ_BYTE/SZ_HALF/SZ_WORD).
- One natural sub-module, dmem_ext: pure combinational lane select plus sign/zero extension (word, lane, size, signed -> m_dmout).

Test Plan:
- sw at 0x00000010, data 0x12345678, then lw 0x10 next cycle -> m_byteen=4'hF; m_dmout=0x12345678; trace "@00003000: *00000010 <= 12345678".
- sb 0xAB at 0x11, then lb 0x11 / lbu 0x11 -> word becomes 0x1234AB78; lb=0xFFFFFFAB, lbu=0x000000AB; m_byteen=4'b0010.
- sh 0x8001 at 0x12, then lh 0x12 / lhu 0x12 -> word becomes 0x8001AB78; lh=0xFFFF8001, lhu=0x00008001.
- Misaligned cases: sw at 0x13 and lh at 0x11 -> m_addr_err=1, m_byteen=0, memory unchanged, m_dmout=0, no trace.
- Out-of-range: lw at 0x3000 -> m_addr_err=1, m_dmout=0.
- Reset test: assert reset=0 for one cycle while presenting sw 0x20 = 0xFFFFFFFF, then lw 0x10 and lw 0x20 -> both read 0, no trace. Then a bubble (instr=0) -> all outputs 0.

Source files
------------

// File: rtl/m_stage_dmem_pkg.sv
// Shared definitions for the memory-stage data memory: load/store opcodes
// and the access-size encoding used by the decoder and the load extender.
package m_stage_dmem_pkg;

    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_SW  = 6'h2b;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SB  = 6'h28;

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } mem_size_e;

endpackage

// File: rtl/m_stage_dmem_ext.sv
// Load extender: picks the addressed byte/half out of a memory word and
// sign- or zero-extends it. SZ_NONE yields zero.
module dmem_ext
    import m_stage_dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] dout
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;
    mem_size_e   sz;

    // Lane select followed by extension to 32 bits.
    always_comb begin
        sz       = mem_size_e'(size);
        half_sel = lane[1] ? word[31:16] : word[15:0];
        byte_sel = word[8*lane +: 8];
        dout     = '0;
        case (sz)
            SZ_WORD: dout = word;
            SZ_HALF: dout = {{16{is_signed & half_sel[15]}}, half_sel};
            SZ_BYTE: dout = {{24{is_signed & byte_sel[7]}}, byte_sel};
            default: dout = '0;
        endcase
    end

endmodule

// File: rtl/m_stage_dmem.sv
// Memory-stage data memory and load/store unit. Stores commit with byte
// enables at the clock edge; loads return extended data combinationally.
// Misaligned or out-of-range accesses are suppressed and flagged.
module m_stage_dmem
    import m_stage_dmem_pkg::*;
#(
    parameter int DEPTH  = 3072,
    parameter int ADDR_W = 12,
    parameter bit LOG_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_instr,
    input  logic [31:0] m_aluout,
    input  logic [31:0] m_DMinput,
    input  logic [31:0] m_pc,
    output logic [31:0] m_dmout,
    output logic        m_is_load,
    output logic        m_is_store,
    output logic        m_addr_err,
    output logic [3:0]  m_byteen
);

    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);

    logic [31:0]       mem_q [0:DEPTH-1];
    logic [31:0]       wr_word_d;
    logic [31:0]       wr_data;
    logic [31:0]       rd_word;
    logic [ADDR_W-1:0] idx;
    logic [1:0]        lane;
    mem_size_e         size;
    mem_size_e         ext_size;
    logic              is_signed;
    logic              misaligned;
    logic              out_of_range;
    logic              unused_instr_bits;

    // Only the opcode field matters to this stage.
    assign unused_instr_bits = ^m_instr[25:0];

    // Opcode decode into access kind, size and signedness.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave it unassigned and infer a latch.
        m_is_load  = 1'b0;
        m_is_store = 1'b0;
        size       = SZ_NONE;
        is_signed  = 1'b0;
        case (m_instr[31:26])
            OP_LW:  begin m_is_load  = 1'b1; size = SZ_WORD; end
            OP_LH:  begin m_is_load  = 1'b1; size = SZ_HALF; is_signed = 1'b1; end
            OP_LHU: begin m_is_load  = 1'b1; size = SZ_HALF; end
            OP_LB:  begin m_is_load  = 1'b1; size = SZ_BYTE; is_signed = 1'b1; end
            OP_LBU: begin m_is_load  = 1'b1; size = SZ_BYTE; end
            OP_SW:  begin m_is_store = 1'b1; size = SZ_WORD; end
            OP_SH:  begin m_is_store = 1'b1; size = SZ_HALF; end
            OP_SB:  begin m_is_store = 1'b1; size = SZ_BYTE; end
            default: ;
        endcase
    end

    // Address checks, byte enables, store data replication and merged word.
    always_comb begin
        idx          = m_aluout[ADDR_W+1:2];
        lane         = m_aluout[1:0];
        misaligned   = ((size == SZ_WORD) && (lane != 2'd0)) ||
                       ((size == SZ_HALF) && lane[0]);
        out_of_range = (m_aluout >= ADDR_LIMIT);
        m_addr_err   = (m_is_load || m_is_store) && (misaligned || out_of_range);

        m_byteen = 4'b0000;
        wr_data  = m_DMinput;
        if (m_is_store && !m_addr_err) begin
            case (size)
                SZ_WORD: m_byteen = 4'b1111;
                SZ_HALF: m_byteen = 4'b0011 << lane;
                SZ_BYTE: m_byteen = 4'b0001 << lane;
                default: m_byteen = 4'b0000;
            endcase
        end
        case (size)
            SZ_HALF: wr_data = {2{m_DMinput[15:0]}};
            SZ_BYTE: wr_data = {4{m_DMinput[7:0]}};
            default: wr_data = m_DMinput;
        endcase

        // Out-of-range indices never reach the load result or a write.
        rd_word  = m_addr_err ? 32'h0 : mem_q[idx];
        ext_size = (m_is_load && !m_addr_err) ? size : SZ_NONE;

        for (int l = 0; l < 4; l++) begin
            wr_word_d[8*l +: 8] = m_byteen[l] ? wr_data[8*l +: 8] : rd_word[8*l +: 8];
        end
    end

    dmem_ext u_ext (
        .word      (rd_word),
        .lane      (lane),
        .size      (ext_size),
        .is_signed (is_signed),
        .dout      (m_dmout)
    );

    // Memory array: cleared on reset, otherwise commits the merged store word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: the whole array is cleared on reset, which rules out a
            // RAM macro; software relies on zeroed data memory after reset.
            for (int i = 0; i < DEPTH; i++) begin
                // NOTE: non-blocking assignment so every read in this edge
                // sees pre-edge state.
                mem_q[i] <= '0;
            end
        end else if (m_byteen != 4'b0000) begin
            mem_q[idx] <= wr_word_d;
        end
    end

    // Store trace, one line per committed write.
    always_ff @(posedge clk) begin
        if (LOG_EN && reset && (m_byteen != 4'b0000)) begin
            $write("@%08h: *%08h <= %08h\n", m_pc, {m_aluout[31:2], 2'b00}, wr_word_d);
        end
    end

endmodule

// File: tb/tb_m_stage_dmem.sv
// Bench for m_stage_dmem: directed table, reset sequence, then random
// traffic checked against a byte-addressed memory model.
module tb_m_stage_dmem;
    import m_stage_dmem_pkg::*;

    localparam int          DEPTH = 3072;
    localparam int unsigned LIMIT = 4 * DEPTH;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m_instr, m_aluout, m_DMinput, m_pc;
    logic [31:0] m_dmout;
    logic        m_is_load, m_is_store, m_addr_err;
    logic [3:0]  m_byteen;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] bmem [0:LIMIT-1];

    typedef struct {
        logic [31:0] dmout;
        logic        ld;
        logic        st;
        logic        err;
        logic [3:0]  be;
    } exp_t;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        exp_t        e;
    } vec_t;

    m_stage_dmem #(.DEPTH(DEPTH), .ADDR_W(12), .LOG_EN(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .m_instr    (m_instr),
        .m_aluout   (m_aluout),
        .m_DMinput  (m_DMinput),
        .m_pc       (m_pc),
        .m_dmout    (m_dmout),
        .m_is_load  (m_is_load),
        .m_is_store (m_is_store),
        .m_addr_err (m_addr_err),
        .m_byteen   (m_byteen)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    task automatic check_exp(input string tag, input exp_t e);
        check({tag, ".dmout"},  m_dmout,           e.dmout);
        check({tag, ".load"},   32'(m_is_load),    32'(e.ld));
        check({tag, ".store"},  32'(m_is_store),   32'(e.st));
        check({tag, ".err"},    32'(m_addr_err),   32'(e.err));
        check({tag, ".byteen"}, 32'(m_byteen),     32'(e.be));
    endtask

    // Access width in bytes (0 = not a memory op), plus kind and signedness.
    function automatic int unsigned op_bytes(input logic [5:0] op, output bit sgn,
                                             output bit ld, output bit st);
        sgn = 0; ld = 0; st = 0;
        case (op)
            OP_LW:  begin ld = 1; return 4; end
            OP_LH:  begin ld = 1; sgn = 1; return 2; end
            OP_LHU: begin ld = 1; return 2; end
            OP_LB:  begin ld = 1; sgn = 1; return 1; end
            OP_LBU: begin ld = 1; return 1; end
            OP_SW:  begin st = 1; return 4; end
            OP_SH:  begin st = 1; return 2; end
            OP_SB:  begin st = 1; return 1; end
            default: return 0;
        endcase
    endfunction

    function automatic exp_t model_eval(input logic [31:0] instr, input logic [31:0] addr);
        exp_t        e;
        bit          sgn, ld, st;
        int unsigned n;
        logic [63:0] v;
        e.dmout = '0; e.ld = 0; e.st = 0; e.err = 0; e.be = '0;
        n = op_bytes(instr[31:26], sgn, ld, st);
        if (n == 0) return e;
        e.ld = ld;
        e.st = st;
        if ((addr % n) != 0 || addr >= LIMIT) begin
            e.err = 1;
            return e;
        end
        if (st) e.be = 4'(((1 << n) - 1) << (addr % 4));
        if (ld) begin
            v = '0;
            for (int k = 0; k < int'(n); k++) v |= 64'(bmem[addr + k]) << (8 * k);
            if (sgn && v[8*n-1]) v |= ~((64'd1 << (8 * n)) - 64'd1);
            e.dmout = v[31:0];
        end
        return e;
    endfunction

    // Model update for the edge that is about to be sampled.
    task automatic commit();
        exp_t        e;
        bit          sgn, ld, st;
        int unsigned n;
        if (!reset) begin
            for (int i = 0; i < int'(LIMIT); i++) bmem[i] = 8'h00;
        end else begin
            e = model_eval(m_instr, m_aluout);
            n = op_bytes(m_instr[31:26], sgn, ld, st);
            if (e.st && !e.err)
                for (int k = 0; k < int'(n); k++) bmem[m_aluout + k] = m_DMinput[8*k +: 8];
        end
    endtask

    task automatic drive(input logic r, input logic [31:0] instr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] pc);
        reset = r; m_instr = instr; m_aluout = addr; m_DMinput = data; m_pc = pc;
        #4;
    endtask

    task automatic tick();
        @(posedge clk);
        commit();
        #1;
    endtask

    function automatic vec_t mk(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] dm, input logic ld, input logic st,
                                input logic err, input logic [3:0] be);
        vec_t v;
        v.op = op; v.addr = a; v.data = d;
        v.e.dmout = dm; v.e.ld = ld; v.e.st = st; v.e.err = err; v.e.be = be;
        return v;
    endfunction

    vec_t vecs [31];
    exp_t e_none;

    initial begin
        vecs[0]  = mk(OP_SW,  32'h10,       32'h12345678, 32'h0,        0, 1, 0, 4'hF);
        vecs[1]  = mk(OP_LW,  32'h10,       32'h0,        32'h12345678, 1, 0, 0, 4'h0);
        vecs[2]  = mk(OP_SB,  32'h11,       32'h000000AB, 32'h0,        0, 1, 0, 4'h2);
        vecs[3]  = mk(OP_LW,  32'h10,       32'h0,        32'h1234AB78, 1, 0, 0, 4'h0);
        vecs[4]  = mk(OP_LB,  32'h11,       32'h0,        32'hFFFFFFAB, 1, 0, 0, 4'h0);
        vecs[5]  = mk(OP_LBU, 32'h11,       32'h0,        32'h000000AB, 1, 0, 0, 4'h0);
        vecs[6]  = mk(OP_SH,  32'h12,       32'h00008001, 32'h0,        0, 1, 0, 4'hC);
        vecs[7]  = mk(OP_LH,  32'h12,       32'h0,        32'hFFFF8001, 1, 0, 0, 4'h0);
        vecs[8]  = mk(OP_LHU, 32'h12,       32'h0,        32'h00008001, 1, 0, 0, 4'h0);
        vecs[9]  = mk(OP_LW,  32'h10,       32'h0,        32'h8001AB78, 1, 0, 0, 4'h0);
        vecs[10] = mk(OP_SW,  32'h13,       32'hDEADBEEF, 32'h0,        0, 1, 1, 4'h0);
        vecs[11] = mk(OP_LH,  32'h11,       32'h0,        32'h0,        1, 0, 1, 4'h0);
        vecs[12] = mk(OP_LW,  32'h10,       32'h0,        32'h8001AB78, 1, 0, 0, 4'h0);
        vecs[13] = mk(OP_LW,  32'h3000,     32'h0,        32'h0,        1, 0, 1, 4'h0);
        vecs[14] = mk(OP_SB,  32'h2FFF,     32'h0000005A, 32'h0,        0, 1, 0, 4'h8);
        vecs[15] = mk(OP_LBU, 32'h2FFF,     32'h0,        32'h0000005A, 1, 0, 0, 4'h0);
        vecs[16] = mk(OP_LW,  32'h2FFC,     32'h0,        32'h5A000000, 1, 0, 0, 4'h0);
        vecs[17] = mk(OP_SB,  32'h3000,     32'h00000077, 32'h0,        0, 1, 1, 4'h0);
        vecs[18] = mk(6'h0F,  32'h13,       32'hFFFFFFFF, 32'h0,        0, 0, 0, 4'h0);
        vecs[19] = mk(OP_LW,  32'hFFFFFFF0, 32'h0,        32'h0,        1, 0, 1, 4'h0);
        vecs[20] = mk(OP_SB,  32'h40,       32'hFFFFFF11, 32'h0,        0, 1, 0, 4'h1);
        vecs[21] = mk(OP_SB,  32'h41,       32'hFFFFFF22, 32'h0,        0, 1, 0, 4'h2);
        vecs[22] = mk(OP_SB,  32'h42,       32'hFFFFFF33, 32'h0,        0, 1, 0, 4'h4);
        vecs[23] = mk(OP_SB,  32'h43,       32'hFFFFFF44, 32'h0,        0, 1, 0, 4'h8);
        vecs[24] = mk(OP_LW,  32'h40,       32'h0,        32'h44332211, 1, 0, 0, 4'h0);
        vecs[25] = mk(OP_SH,  32'h42,       32'h1234ABCD, 32'h0,        0, 1, 0, 4'hC);
        vecs[26] = mk(OP_LW,  32'h40,       32'h0,        32'hABCD2211, 1, 0, 0, 4'h0);
        vecs[27] = mk(OP_LH,  32'h40,       32'h0,        32'h00002211, 1, 0, 0, 4'h0);
        vecs[28] = mk(OP_LB,  32'h43,       32'h0,        32'hFFFFFFAB, 1, 0, 0, 4'h0);
        vecs[29] = mk(OP_LH,  32'h42,       32'h0,        32'hFFFFABCD, 1, 0, 0, 4'h0);
        vecs[30] = mk(OP_LHU, 32'h2FFE,     32'h0,        32'h00005A00, 1, 0, 0, 4'h0);

        e_none.dmout = '0; e_none.ld = 0; e_none.st = 0; e_none.err = 0; e_none.be = '0;

        // Reset state with bubbles in the pipe.
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
            check_exp($sformatf("rst%0d", i), e_none);
            tick();
        end

        // Directed table from the test plan and extra lane/boundary cases.
        for (int i = 0; i < 31; i++) begin
            drive(1'b1, {vecs[i].op, 26'h00002A5}, vecs[i].addr, vecs[i].data, 32'h00003000);
            check_exp($sformatf("vec%0d", i), vecs[i].e);
            tick();
        end

        // Reset wins over a store presented in the same cycle.
        begin
            exp_t e;
            e = e_none; e.st = 1; e.be = 4'hF;
            drive(1'b0, {OP_SW, 26'h0}, 32'h20, 32'hFFFFFFFF, 32'h00003100);
            check_exp("rst_sw", e);
            tick();
            e = e_none; e.ld = 1;
            drive(1'b1, {OP_LW, 26'h0}, 32'h10, 32'h0, 32'h00003104);
            check_exp("rst_lw10", e);
            tick();
            drive(1'b1, {OP_LW, 26'h0}, 32'h20, 32'h0, 32'h00003108);
            check_exp("rst_lw20", e);
            tick();
            drive(1'b1, {OP_LW, 26'h0}, 32'h2FFC, 32'h0, 32'h0000310C);
            check_exp("rst_lw2ffc", e);
            tick();
            drive(1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
            check_exp("bubble", e_none);
            tick();
        end

        // Random traffic against the byte-addressed model.
        for (int i = 0; i < 400; i++) begin
            logic [5:0]  op;
            logic [31:0] a;
            logic        r;
            exp_t        e;
            case ($urandom_range(0, 9))
                0: op = OP_LW;  1: op = OP_LH;  2: op = OP_LHU; 3: op = OP_LB;
                4: op = OP_LBU; 5: op = OP_SW;  6: op = OP_SH;  7: op = OP_SB;
                8: op = 6'h00;
                default: op = 6'($urandom);
            endcase
            case ($urandom_range(0, 9))
                7:       a = LIMIT - 8 + $urandom_range(0, 15);
                8:       a = $urandom;
                9:       a = $urandom_range(0, LIMIT - 1);
                default: a = $urandom_range(0, 63);
            endcase
            r = ($urandom_range(0, 63) != 0);
            drive(r, {op, 26'($urandom)}, a, $urandom, 32'h00004000 + 32'(4 * i));
            e = model_eval(m_instr, m_aluout);
            check_exp($sformatf("rnd%0d", i), e);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
